// File: rtl/risc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_mem_pkg
// Description : Shared types and constants for the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_mem_pkg;

    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 16;
    localparam int STREAK_W = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    typedef logic owner_t;
    localparam owner_t OWN_IF = 1'b0;
    localparam owner_t OWN_D  = 1'b1;

    typedef logic [STREAK_W-1:0] streak_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational fetch/data priority decision with streak limit.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import risc_mem_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic    if_req_i,
    input  logic    d_req_i,
    input  streak_t streak_i,
    output logic    grant_valid_o,
    output owner_t  grant_owner_o
);

    logic w_fetch_forced;

    // Fetch only beats data when both contend and data has used up its streak.
    assign w_fetch_forced = if_req_i && (streak_i == STREAK_W'(MAX_DATA_STREAK));

    assign grant_valid_o  = if_req_i | d_req_i;
    assign grant_owner_o  = (d_req_i && !w_fetch_forced) ? OWN_D : OWN_IF;

endmodule
`default_nettype wire

// File: rtl/risc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : risc_mem_arbiter
// Description : Shares one single-port memory between fetch and load/store.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_mem_arbiter
    import risc_mem_pkg::*;
#(
    parameter int DW              = DW_DEF,
    parameter int AW              = AW_DEF,
    parameter int MEM_LAT         = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int WCNT_W = 3;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    streak_t             streak_q, streak_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d;
    logic [DW-1:0]       d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                busy_q, busy_d;

    logic                w_grant_valid;
    owner_t              w_grant_owner;

    mem_arb_pick #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_pick (
        .if_req_i      (if_req),
        .d_req_i       (d_req),
        .streak_i      (streak_q),
        .grant_valid_o (w_grant_valid),
        .grant_owner_o (w_grant_owner)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        streak_d    = streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    state_d  = ST_ISSUE;
                    owner_d  = w_grant_owner;
                    mem_en_d = 1'b1;
                    if (w_grant_owner == OWN_D) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        we_d        = d_we;
                        mem_we_d    = d_we;
                        // Only contested data grants lengthen the streak.
                        if (if_req && (streak_q != STREAK_W'(MAX_DATA_STREAK))) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        mem_addr_d = if_addr;
                        we_d       = 1'b0;
                        streak_d   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wcnt_d  = WCNT_W'(MEM_LAT - 1);
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/risc_mem_arbiter.md
Name: risc_mem_arbiter

Overview:
Shares one single-port unified memory between the 16-bit RISC core's instruction-fetch port and its load/store data port. Arbitrates requests and sequences the memory access. Returns read data with a one-cycle ack to the winner. Sits between the datapath's fetch/LSU request signals and the memory macro, and replaces separate instruction and data memories.

Parameters:
DW, 16, data width of memory words and ports
AW, 16, address width
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal 1..4
MAX_DATA_STREAK, 4, maximum consecutive contested data grants before fetch is forced to win; legal 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address, stable while if_req is high
if_rdata  out  DW  fetch read data, valid when if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid when d_ack=1
d_ack  out  1  one-cycle data completion pulse
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  high in every state except IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- All outputs are registered. Reset values: every output is 0, the FSM is in IDLE, and the streak counter is 0.
- FSM: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE. A transaction occupies exactly MEM_LAT+3 cycles.
- IDLE: sample the requests.
  - With no requests, stay in IDLE.
  - Otherwise pick a winner, latch its addr/we/wdata and owner, and go to ISSUE.
- Priority:
  - With only one request, that requester wins.
  - When both request, data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter:
  - Increments on each data grant made while if_req=1.
  - Clears on any fetch grant.
  - Holds on an uncontested data grant.
  - Saturates at MAX_DATA_STREAK.
- ISSUE: mem_en=1 with the latched addr/wdata. mem_we=1 only for a data store; fetch is always a read.
- WAIT: mem_en=0. Count MEM_LAT cycles. On the final WAIT cycle, capture mem_rdata into the owner's rdata register.
- Stores also wait MEM_LAT cycles, so timing is uniform; their rdata register is unchanged.
- RESP: pulse the owner's ack for one cycle. The non-owner's ack stays 0. No arbitration occurs in RESP.
- Handshake:
  - A requester may change addr/we/wdata only in the cycle after its ack.
  - req still high in IDLE after RESP is a new request, so back-to-back accesses are legal.
- Latency: with a request sampled in IDLE at cycle T, mem_en is at T+1 and ack is at T+2+MEM_LAT.
- A request dropped before it is granted is ignored.
- A request dropped while in flight is a protocol violation. The access still completes and ack still pulses.
- if_rdata/d_rdata hold their last captured value between acks.
- Reset mid-operation: abort immediately and return to IDLE with all outputs 0. The pending access gets no ack. mem_en is never asserted in the cycle after reset is sampled high.
- Addresses are passed through unmodified, with no wrap or range checking.

Decomposition:
- Package risc_mem_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - owner encoding (OWN_IF=0, OWN_D=1);
  - default DW/AW constants;
  - a streak counter width of 4 bits.
- One sub-module, mem_arb_pick: purely combinational priority/streak decision. Inputs: if_req, d_req, streak. Outputs: grant_valid, grant_owner. The FSM, streak register and datapath latches stay in risc_mem_arbiter.

Test Plan:
1. MEM_LAT=1, reset released, if_req=1 with if_addr=0x0010 at cycle 0; the memory model returns 0xA5A5 -> mem_en=1, mem_we=0, mem_addr=0x0010 at cycle 1; if_ack=1, if_rdata=0xA5A5 at cycle 3; d_ack stays 0.
2. d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234 -> a single mem_en cycle with mem_we=1, mem_addr=0x0200, mem_wdata=0x1234; d_ack at cycle 3; a subsequent load of 0x0200 returns d_rdata=0x1234.
3. Both req held high continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; transactions are spaced 4 cycles apart (MEM_LAT=1).
4. MEM_LAT=3, fetch of 0x0004 at cycle 0 -> mem_en at cycle 1, capture at cycle 4, if_ack at cycle 5; busy=1 for cycles 1-5.
5. Reset asserted in the WAIT cycle of a data load -> the next cycle has all outputs 0 and busy=0; no d_ack ever pulses for that access.
6. d_req pulsed for one cycle while the arbiter is in WAIT serving a fetch -> the pulse is ignored; only if_ack occurs and there is no further mem_en.
